// File: rtl/i1_seq_pkg.sv
// ============================================================================
// Module      : i1_seq_pkg
// Description : Shared types and constants for the i1 sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i1_seq_pkg;

  localparam int CNT_W_DEF = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam logic [1:0] MODE_WAITACK = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

endpackage

`default_nettype wire

// File: rtl/i1_seq_if.sv
// ============================================================================
// Module      : i1_seq_if
// Description : Job request valid/ready channel into the i1 sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i1_seq_if
  import i1_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_count;
  logic [1:0]       req_mode;

  modport master (output req_valid, output req_count, output req_mode, input req_ready);
  modport slave  (input req_valid, input req_count, input req_mode, output req_ready);

endinterface

`default_nettype wire

// File: rtl/i1_seq_downcnt.sv
// ============================================================================
// Module      : i1_seq_downcnt
// Description : Loadable, enable-gated down-counter with registered zero flag
//               and a combinational 1->0 terminal strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i1_seq_downcnt #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q;

  // Clear beats load beats decrement; a reload on the terminal step lands here as a load.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign term_o  = dec_i & (cnt_q == CNT_W'(1));
  assign count_o = cnt_q;
  assign zero_o  = zero_q;

endmodule

`default_nettype wire

// File: rtl/i1_seq_ctrl.sv
// ============================================================================
// Module      : i1_seq_ctrl
// Description : Job sequencer: valid/ready accept, down-count, registered
//               run/hold/done status. Macro I1_SEQ_WRAPCNT_EN enables wrap_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i1_seq_ctrl
  import i1_seq_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WRAP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ack,
  input  logic              abort,
  i1_seq_if.slave           req,
  output logic [CNT_W-1:0]  count_o,
  output logic              cnt_zero,
  output logic              busy,
  output logic              hold_o,
  output logic              done_pulse,
  output logic [WRAP_W-1:0] wrap_cnt
);

  state_e           state_q, state_d;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] rld_q;
  logic             busy_q, hold_q, done_q, done_d;
  logic             accept, run_step, term, reload;

  assign req.req_ready = rst_n & en & (state_q == IDLE) & ~abort;
  assign accept        = req.req_valid & req.req_ready;
  assign run_step      = (state_q == RUN) & en;
  assign reload        = term & (mode_q == MODE_RELOAD) & ~abort;

  i1_seq_downcnt #(.CNT_W(CNT_W)) u_downcnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (abort),
    .load_i     (accept | reload),
    .load_val_i (accept ? req.req_count : rld_q),
    .dec_i      (run_step),
    .count_o    (count_o),
    .zero_o     (cnt_zero),
    .term_o     (term)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          if (req.req_count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        RUN: if (term) begin
          case (mode_q)
            MODE_RELOAD:  state_d = RUN;
            MODE_WAITACK: state_d = HOLD;
            MODE_ONESHOT, MODE_RSVD: begin
              state_d = DONE;
              done_d  = 1'b1;
            end
            default: state_d = DONE;
          endcase
        end
        HOLD: if (ack && en) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status is registered off the next state so it lines up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_ONESHOT;
      rld_q   <= '0;
      busy_q  <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      hold_q  <= (state_d == HOLD);
      done_q  <= done_d;
      if (accept) begin
        mode_q <= req.req_mode;
        rld_q  <= req.req_count;
      end
    end
  end

  assign busy       = busy_q;
  assign hold_o     = hold_q;
  assign done_pulse = done_q;

`ifdef I1_SEQ_WRAPCNT_EN
  logic [WRAP_W-1:0] wrap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= '0;
    end else if (accept) begin
      wrap_q <= '0;
    end else if (reload && (wrap_q != '1)) begin
      wrap_q <= wrap_q + WRAP_W'(1);
    end
  end

  assign wrap_cnt = wrap_q;
`else
  assign wrap_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i1_seq_ctrl.sv
// ============================================================================
// Module      : tb_i1_seq_ctrl
// Description : Self-checking bench for i1_seq_ctrl: vector table, directed
//               corner sequences and randomized traffic against a job model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i1_seq_ctrl;
  import i1_seq_pkg::*;

  localparam int CW = 7;
  localparam int WW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          ack   = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] count_o;
  logic          cnt_zero, busy, hold_o, done_pulse;
  logic [WW-1:0] wrap_cnt;

  i1_seq_if #(.CNT_W(CW)) rq ();

  i1_seq_ctrl #(.CNT_W(CW), .WRAP_W(WW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ack        (ack),
    .abort      (abort),
    .req        (rq),
    .count_o    (count_o),
    .cnt_zero   (cnt_zero),
    .busy       (busy),
    .hold_o     (hold_o),
    .done_pulse (done_pulse),
    .wrap_cnt   (wrap_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Job-level model: phase 0 idle, 1 counting, 2 waiting for ack, 3 finishing.
  int m_phase, m_cnt, m_rld, m_mode, m_wrap, m_done;

  function automatic void m_reset();
    m_phase = 0; m_cnt = 0; m_rld = 0; m_mode = 0; m_wrap = 0; m_done = 0;
  endfunction

  function automatic void m_step(input bit e, input bit v, input int c, input int md,
                                 input bit a, input bit ab);
    m_done = 0;
    if (ab) begin
      m_phase = 0;
      m_cnt   = 0;
    end else if (m_phase == 0) begin
      if (e && v) begin
        m_rld = c; m_mode = md; m_wrap = 0; m_cnt = c;
        if (c == 0) begin m_phase = 3; m_done = 1; end
        else m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (e) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          if (m_mode == 1) begin
            m_cnt = m_rld;
            if (m_wrap < 15) m_wrap = m_wrap + 1;
          end else if (m_mode == 2) begin
            m_phase = 2;
          end else begin
            m_phase = 3; m_done = 1;
          end
        end
      end
    end else if (m_phase == 2) begin
      if (a && e) begin m_phase = 0; m_done = 1; end
    end else begin
      m_phase = 0;
    end
  endfunction

  function automatic int exp_wrap();
`ifdef I1_SEQ_WRAPCNT_EN
    return m_wrap;
`else
    return 0;
`endif
  endfunction

  task automatic check_outs();
    chk("count_o",    int'(count_o),    m_cnt);
    chk("cnt_zero",   int'(cnt_zero),   int'(m_cnt == 0));
    chk("busy",       int'(busy),       int'(m_phase != 0));
    chk("hold_o",     int'(hold_o),     int'(m_phase == 2));
    chk("done_pulse", int'(done_pulse), m_done);
    chk("wrap_cnt",   int'(wrap_cnt),   exp_wrap());
  endtask

  // Called at a negedge: drive, sample req_ready, clock once, compare at next negedge.
  task automatic cycle(input bit e, input bit v, input int c, input int md,
                       input bit a, input bit ab, output bit rdy);
    en = e; rq.req_valid = v; rq.req_count = CW'(c); rq.req_mode = 2'(md);
    ack = a; abort = ab;
    #1;
    rdy = rq.req_ready;
    chk("req_ready", int'(rdy), int'(e && (m_phase == 0) && !ab));
    m_step(e, v, c, md, a, ab);
    @(posedge clk);
    @(negedge clk);
    check_outs();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_count"}, int'(count_o),      0);
    chk({tag, "_zero"},  int'(cnt_zero),     1);
    chk({tag, "_busy"},  int'(busy),         0);
    chk({tag, "_hold"},  int'(hold_o),       0);
    chk({tag, "_done"},  int'(done_pulse),   0);
    chk({tag, "_wrap"},  int'(wrap_cnt),     0);
    chk({tag, "_ready"}, int'(rq.req_ready), 0);
  endtask

  typedef struct {
    bit en, valid;
    int cnt, mode;
    bit ack, abort;
    int x_ready, x_count, x_busy, x_hold, x_done;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input bit e, input bit v, input int c, input int md,
                              input bit a, input bit ab, input int xr, input int xc,
                              input int xb, input int xh, input int xd);
    vec_t t;
    t.en = e; t.valid = v; t.cnt = c; t.mode = md; t.ack = a; t.abort = ab;
    t.x_ready = xr; t.x_count = xc; t.x_busy = xb; t.x_hold = xh; t.x_done = xd;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rdy;
    int lat;
    rq.req_valid = 1'b0; rq.req_count = '0; rq.req_mode = 2'b00;
    m_reset();

    //            en v  cnt md ack ab  rdy cnt busy hold done
    tbl[0]  = mk(1, 1, 3, 0, 0, 0,  1,  3,  1,  0,  0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0,  0,  2,  1,  0,  0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0,  0,  1,  1,  0,  0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0,  0,  0,  1,  0,  1);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0,  1,  0,  0,  0,  0);
    tbl[6]  = mk(1, 1, 1, 2, 0, 0,  1,  1,  1,  0,  0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 0,  0,  0,  1,  1,  0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0,  0,  0,  1,  1,  0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 0,  0,  0,  1,  1,  0);
    tbl[10] = mk(1, 0, 0, 0, 1, 0,  0,  0,  0,  0,  1);
    tbl[11] = mk(1, 0, 0, 0, 0, 0,  1,  0,  0,  0,  0);
    tbl[12] = mk(1, 1, 0, 0, 0, 0,  1,  0,  1,  0,  1);
    tbl[13] = mk(1, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0);
    tbl[14] = mk(1, 1, 5, 0, 0, 1,  0,  0,  0,  0,  0);
    tbl[15] = mk(0, 1, 0, 0, 0, 0,  0,  0,  0,  0,  0);

    // Reset state, with en and req_valid high to show req_ready is held low.
    en = 1'b1; rq.req_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    en = 1'b0; rq.req_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].en, tbl[i].valid, tbl[i].cnt, tbl[i].mode, tbl[i].ack, tbl[i].abort, rdy);
      chk($sformatf("tbl%0d_ready", i), int'(rdy),        tbl[i].x_ready);
      chk($sformatf("tbl%0d_count", i), int'(count_o),    tbl[i].x_count);
      chk($sformatf("tbl%0d_busy", i),  int'(busy),       tbl[i].x_busy);
      chk($sformatf("tbl%0d_hold", i),  int'(hold_o),     tbl[i].x_hold);
      chk($sformatf("tbl%0d_done", i),  int'(done_pulse), tbl[i].x_done);
    end

    // Freeze: count 4, en low for three cycles after the second decrement.
    cycle(1, 1, 4, 0, 0, 0, rdy);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      cycle(!(k >= 3 && k <= 5), 0, 0, 0, 0, 0, rdy);
      if (k == 5) chk("freeze_hold_count", int'(count_o), 2);
      if (done_pulse) begin lat = k; break; end
    end
    chk("freeze_latency", lat, 7);
    cycle(1, 0, 0, 0, 0, 0, rdy);

    // Auto-reload long enough to saturate wrap_cnt, then abort.
    cycle(1, 1, 2, 1, 0, 0, rdy);
    for (int k = 1; k <= 36; k++) begin
      cycle(1, 0, 0, 0, k[0], 0, rdy);
      if (k % 2 == 1) chk("reload_count_odd", int'(count_o), 1);
    end
`ifdef I1_SEQ_WRAPCNT_EN
    chk("wrap_saturated", int'(wrap_cnt), 15);
`else
    chk("wrap_tied_zero", int'(wrap_cnt), 0);
`endif
    cycle(1, 0, 0, 0, 0, 1, rdy);
    chk("reload_abort_done", int'(done_pulse), 0);
    cycle(1, 0, 0, 0, 0, 0, rdy);
    chk("reload_abort_done_late", int'(done_pulse), 0);

    // Wait-ack released after five idle HOLD cycles.
    cycle(1, 1, 1, 2, 0, 0, rdy);
    for (int k = 0; k < 6; k++) cycle(1, 0, 0, 0, 0, 0, rdy);
    cycle(1, 0, 0, 0, 1, 0, rdy);
    chk("waitack_done", int'(done_pulse), 1);
    cycle(1, 0, 0, 0, 0, 0, rdy);

    // Collisions: abort on the 1->0 step, abort with ack, abort with a zero job offered.
    cycle(1, 1, 1, 0, 0, 0, rdy);
    cycle(1, 0, 0, 0, 0, 1, rdy);
    chk("abort_term_done", int'(done_pulse), 0);
    cycle(1, 0, 0, 0, 0, 0, rdy);
    chk("abort_term_done_late", int'(done_pulse), 0);
    cycle(1, 1, 1, 2, 0, 0, rdy);
    cycle(1, 0, 0, 0, 0, 0, rdy);
    cycle(1, 0, 0, 0, 1, 1, rdy);
    chk("abort_ack_done", int'(done_pulse), 0);
    cycle(1, 1, 0, 0, 0, 1, rdy);
    chk("abort_zero_job_busy", int'(busy), 0);
    cycle(1, 0, 0, 0, 0, 0, rdy);
    chk("abort_zero_job_done", int'(done_pulse), 0);

    // Asynchronous reset while running with count_o at 5.
    cycle(1, 1, 9, 0, 0, 0, rdy);
    for (int k = 0; k < 4; k++) cycle(1, 0, 0, 0, 0, 0, rdy);
    chk("pre_reset_count", int'(count_o), 5);
    en = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 2500; n++) begin
      int r, c;
      r = int'($urandom_range(0, 9));
      c = (r == 9) ? int'($urandom_range(0, 127)) : r;
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, c,
            int'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
            $urandom_range(0, 39) == 0, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
